// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        while ((32'sd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_seq_converter_digit_cell.sv
// One BCD digit of the double-dabble chain: add-3 adjust followed by a one-bit left shift.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               shift_in,
    output logic [DIGIT_W-1:0] digit_next,
    output logic               carry_out
);

    logic [DIGIT_W-1:0] adj_s;

    // Digits of 5 or more get +3 so the following doubling carries correctly in decimal
    always_comb begin
        if (digit >= 4'd5) begin
            adj_s = digit + 4'd3;
        end else begin
            adj_s = digit;
        end
    end

    assign digit_next = {adj_s[DIGIT_W-2:0], shift_in};
    assign carry_out  = adj_s[DIGIT_W-1];

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter: one input bit per clock, start/ready/done handshake.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      is_signed,
    input  logic [WIDTH-1:0]          bin_in,
    output logic                      ready,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      neg,
    output logic                      ovf
);

    localparam int CNT_W = ceil_log2(WIDTH);
    localparam int BCD_W = DIGIT_W * DIGITS;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   mag_r;
    logic [BCD_W-1:0]   work_r;
    logic [BCD_W-1:0]   work_nxt_s;
    logic               neg_work_r;
    logic               ovf_work_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [DIGITS:0]    chain_s;
    logic               last_bit_s;

    assign chain_s[0] = mag_r[WIDTH-1];
    assign last_bit_s = (cnt_r == {CNT_W{1'b0}});

    // The top digit's carry-out is the bit lost off the end, which drives overflow
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .digit      (work_r[g*DIGIT_W +: DIGIT_W]),
            .shift_in   (chain_s[g]),
            .digit_next (work_nxt_s[g*DIGIT_W +: DIGIT_W]),
            .carry_out  (chain_s[g+1])
        );
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Status flags registered from the next state, so they always mirror state_r
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= (state_nxt_s == IDLE);
            busy  <= (state_nxt_s != IDLE);
            done  <= (state_nxt_s == DONE);
        end
    end

    // Working registers: load magnitude on acceptance, shift once per SHIFT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_r      <= {WIDTH{1'b0}};
            work_r     <= {BCD_W{1'b0}};
            neg_work_r <= 1'b0;
            ovf_work_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (is_signed && bin_in[WIDTH-1]) begin
                            mag_r <= ~bin_in + {{(WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            mag_r <= bin_in;
                        end
                        work_r     <= {BCD_W{1'b0}};
                        neg_work_r <= is_signed & bin_in[WIDTH-1];
                        ovf_work_r <= 1'b0;
                        cnt_r      <= CNT_W'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    mag_r      <= {mag_r[WIDTH-2:0], 1'b0};
                    work_r     <= work_nxt_s;
                    ovf_work_r <= ovf_work_r | chain_s[DIGITS];
                    if (!last_bit_s) begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result registers take the final shift's value and then hold through later conversions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_out <= {BCD_W{1'b0}};
            neg     <= 1'b0;
            ovf     <= 1'b0;
        end else if (state_r == SHIFT && last_bit_s) begin
            bcd_out <= work_nxt_s;
            neg     <= neg_work_r;
            ovf     <= ovf_work_r | chain_s[DIGITS];
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter at (16,5), (16,4) and (8,3) against a decimal reference model.
module tb_bcd_seq_converter;

    typedef struct {
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
        longint      cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [2:0]  sg_v;
    logic [2:0]  ready_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  neg_v;
    logic [2:0]  ovf_v;
    logic [15:0] bin_a [3];
    logic [19:0] bcd0;
    logic [15:0] bcd1;
    logic [11:0] bcd2;
    logic [19:0] last_bcd [3];
    exp_t        sb_q [3][$];
    longint      cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) u0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .is_signed(sg_v[0]), .bin_in(bin_a[0]),
        .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .bcd_out(bcd0),
        .neg(neg_v[0]), .ovf(ovf_v[0]));

    bcd_seq_converter #(.WIDTH(16), .DIGITS(4)) u1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .is_signed(sg_v[1]), .bin_in(bin_a[1]),
        .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .bcd_out(bcd1),
        .neg(neg_v[1]), .ovf(ovf_v[1]));

    bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) u2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .is_signed(sg_v[2]), .bin_in(bin_a[2][7:0]),
        .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .bcd_out(bcd2),
        .neg(neg_v[2]), .ovf(ovf_v[2]));

    function automatic int width_of(int i);
        return (i == 2) ? 8 : 16;
    endfunction

    function automatic int digits_of(int i);
        return (i == 0) ? 5 : ((i == 1) ? 4 : 3);
    endfunction

    function automatic logic [19:0] bcd_of(int i);
        if (i == 0) return bcd0;
        if (i == 1) return {4'h0, bcd1};
        return {8'h00, bcd2};
    endfunction

    // Reference: decimal digits of the magnitude by / and %, lower DIGITS digits kept
    function automatic exp_t model(int i, logic [15:0] v, logic sg);
        exp_t   e;
        longint w, val, mag, lim;
        w     = width_of(i);
        val   = longint'(v) & ((64'sd1 << w) - 64'sd1);
        e.neg = sg && (((val >> (w - 1)) & 64'sd1) != 64'sd0);
        mag   = e.neg ? ((64'sd1 << w) - val) : val;
        lim   = 1;
        repeat (digits_of(i)) lim = lim * 10;
        e.ovf = (mag >= lim);
        mag   = mag % lim;
        e.bcd = 20'h0;
        for (int k = 0; k < digits_of(i); k++) begin
            e.bcd[4*k +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        e.cyc = 0;
        return e;
    endfunction

    task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s inst%0d actual=%0h required=%0h t=%0t", name, inst, act, req, $time);
        end
    endtask

    task automatic wait_ready(int i);
        int n;
        n = 0;
        while (ready_v[i] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready_v[i] !== 1'b1) chk("ready_timeout", i, 32'(ready_v[i]), 32'd1);
    endtask

    task automatic push_exp(int i, logic [15:0] v, logic sg);
        exp_t e;
        e     = model(i, v, sg);
        e.cyc = cyc + width_of(i) + 1;
        sb_q[i].push_back(e);
    endtask

    task automatic conv(int i, logic [15:0] v, logic sg);
        wait_ready(i);
        bin_a[i]   = v;
        sg_v[i]    = sg;
        start_v[i] = 1'b1;
        push_exp(i, v, sg);
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every done, otherwise checks the held result
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (ready_v[i] && busy_v[i]) chk("ready_and_busy", i, 32'(busy_v[i]), 32'd0);
                if (done_v[i]) begin
                    if (sb_q[i].size() == 0) begin
                        chk("unexpected_done", i, 32'(done_v[i]), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q[i].pop_front();
                        chk("bcd_out", i, 32'(bcd_of(i)), 32'(e.bcd));
                        chk("neg", i, 32'(neg_v[i]), 32'(e.neg));
                        chk("ovf", i, 32'(ovf_v[i]), 32'(e.ovf));
                        chk("done_cycle", i, 32'(cyc), 32'(e.cyc));
                        last_bcd[i] = e.bcd;
                    end
                end else begin
                    chk("bcd_hold", i, 32'(bcd_of(i)), 32'(last_bcd[i]));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        start_v = 3'b000;
        sg_v    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            bin_a[i]    = 16'h0;
            last_bcd[i] = 20'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", 0, 32'(ready_v[0]), 32'd1);
        chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("rst_done", 0, 32'(done_v[0]), 32'd0);
        chk("rst_bcd", 0, 32'(bcd0), 32'd0);
        chk("rst_neg", 0, 32'(neg_v[0]), 32'd0);
        chk("rst_ovf", 0, 32'(ovf_v[0]), 32'd0);
        chk("rst_ready", 2, 32'(ready_v[2]), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Directed corner values
        conv(0, 16'hFFFF, 1'b0);
        conv(0, 16'h0000, 1'b1);
        conv(0, 16'hFFFF, 1'b1);
        conv(0, 16'h8000, 1'b1);
        conv(1, 16'hFFFF, 1'b0);
        conv(1, 16'd9999, 1'b0);
        conv(1, 16'h8000, 1'b0);

        // Abort mid-conversion after seven shifts
        wait_ready(1);
        conv(0, 16'd12345, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready", 0, 32'(ready_v[0]), 32'd1);
        chk("abort_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("abort_done", 0, 32'(done_v[0]), 32'd0);
        chk("abort_bcd", 0, 32'(bcd0), 32'd0);
        chk("abort_neg", 0, 32'(neg_v[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            sb_q[i].delete();
            last_bcd[i] = 20'h0;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);

        // start held high: one conversion every WIDTH+2 cycles
        conv(0, 16'd4096, 1'b0);
        wait_ready(0);
        start_v[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bin_a[0] = 16'($urandom);
            sg_v[0]  = 1'($urandom_range(1));
            push_exp(0, bin_a[0], sg_v[0]);
            repeat (18) @(negedge clk);
        end
        start_v[0] = 1'b0;

        // start pulsed during SHIFT must be ignored
        conv(0, 16'd4321, 1'b0);
        repeat (4) @(negedge clk);
        bin_a[0]   = 16'd1111;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("busy_ready_low", 0, 32'(ready_v[0]), 32'd0);

        // Randomised conversions
        for (int k = 0; k < 40; k++) begin
            conv(0, 16'($urandom), 1'($urandom_range(1)));
            conv(1, 16'($urandom), 1'($urandom_range(1)));
        end

        // Exhaustive 8-bit sweep, both modes
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 256; v++) begin
                conv(2, 16'(v), 1'(s));
            end
        end

        for (int i = 0; i < 3; i++) wait_ready(i);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("queue_drained", i, 32'(sb_q[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_seq_converter.md
# bcd_seq_converter

Sequential, parametrised binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one input bit per clock. It is the multi-cycle, width-generic successor to the team's 16-bit combinational converter, and feeds the seven-segment and readout display paths. It adds a start/ready/done handshake, runtime signed/unsigned selection, held output registers and overflow detection.

## Interface
- `WIDTH`, default 16: binary input width; must be ≥ 2.
- `DIGITS`, default 5: number of BCD digits produced; must be ≥ 1.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: asynchronous, active-low reset.
- `start` in, 1: request a conversion; accepted only while `ready`=1.
- `is_signed` in, 1: sampled with `start`; 1 means `bin_in` is two's complement.
- `bin_in` in, WIDTH: value to convert; sampled with `start`.
- `ready` out, 1: converter idle and able to accept `start`.
- `busy` out, 1: conversion in progress.
- `done` out, 1: one-cycle pulse when `bcd_out`, `neg` and `ovf` update.
- `bcd_out` out, 4*DIGITS: result; digit 0 (ones) in bits [3:0]; held until the next `done`.
- `neg` out, 1: 1 when the last converted value was negative; always 0 for unsigned conversions.
- `ovf` out, 1: 1 when the magnitude did not fit in DIGITS digits.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE
  - `ready`=1.
  - On `start`=1, latch the magnitude into the working shift register:
    - signed and `bin_in[WIDTH-1]`=1: magnitude = two's complement of `bin_in`.
    - otherwise: magnitude = `bin_in`.
  - On the same edge: clear working digits, latch the negative flag, clear the working overflow, set bit counter to WIDTH-1, go to SHIFT.
- SHIFT, once per cycle:
  - Each working digit ≥ 5 gets +3.
  - Shift left one bit across the chain: each digit's bit 3 moves into the next digit's bit 0; the magnitude MSB moves into digit 0 bit 0.
  - Bit 3 of the top digit, after adjust and before shift, sets the sticky working overflow.
  - When the counter reaches 0, copy working digits, negative flag and overflow to `bcd_out`/`neg`/`ovf`, then go to DONE. Otherwise decrement the counter.
- DONE: `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- `start` outside IDLE is ignored; no queueing.
- Most negative input (e.g. 0x8000 at WIDTH=16): the magnitude 2^(WIDTH-1) is representable unsigned in WIDTH bits and converts correctly.
- Zero converts to all-zero digits; `neg`=0.
- Reset asserted mid-conversion aborts the conversion: state returns to IDLE and no `done` is issued.

## Timing
- Values on reset: state IDLE, `ready`=1, `busy`=0, `done`=0, `bcd_out`=0, `neg`=0, `ovf`=0; working registers and counter 0.
- Acceptance edge is E0. Shift edges are E1..E_WIDTH. Outputs update at E_WIDTH.
- `done` is high in the cycle after E_WIDTH. Latency from `start` to `done` is WIDTH+1 cycles; the default is 17.
- `ready` returns at E_WIDTH+1. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- `busy` = state ∈ {SHIFT, DONE}.
- `ready` = state == IDLE. `ready` and `busy` are never both 1.
- Outputs are registered with no combinational path from inputs. `bcd_out` stays stable throughout the next conversion.

## Structure
- Shared package `bcd_pkg` holds:
  - the state enum (IDLE/SHIFT/DONE);
  - the digit-width constant (4);
  - a `ceil_log2` function used to size the bit counter.
- Sub-module `bcd_digit_cell` is the combinational add-3 adjust for one digit, with the shift-in bit and carry-out bit exposed. It is instantiated DIGITS times by a generate loop.

## Test plan
- Reset mid-SHIFT, after 7 shift cycles of 12345 → `ready`=1 immediately; no `done`; `bcd_out`=0.
- Unsigned 0xFFFF, WIDTH 16, DIGITS 5 → `done` 17 cycles after `start`; `bcd_out`=0x65535; `neg`=0; `ovf`=0.
- Signed 0x8000 → `bcd_out`=0x32768, `neg`=1. Signed 0xFFFF → 0x00001, `neg`=1. Signed 0x0000 → 0x00000, `neg`=0.
- DIGITS=4, unsigned 0xFFFF → `ovf`=1. DIGITS=4, unsigned 9999 → `bcd_out`=0x9999, `ovf`=0.
- Handshake:
  - `start` held high continuously → conversions every 18 cycles.
  - `start` pulsed during SHIFT → ignored; `bcd_out` holds the previous result until the next `done`.
- WIDTH=8, DIGITS=3: sweep all 256 values in both modes against a reference model → every result matches, each with `done` 9 cycles after `start`.
